// File: rtl/bcd_defs.sv
// Shared BCD definitions for the bcd_counter_n slice.
//   BCD_MAX / BCD_MIN : digit limits
//   is_bcd()          : nibble legality check, used for load validation
//   bcd_step()        : single-digit increment/decrement with 9<->0 roll
package bcd_defs;

   localparam int         BCD_W   = 4;
   localparam logic [3:0] BCD_MAX = 4'd9;
   localparam logic [3:0] BCD_MIN = 4'd0;

   function automatic logic is_bcd(input logic [3:0] nib);
      return (nib <= BCD_MAX);
   endfunction

   function automatic logic [3:0] bcd_step(input logic [3:0] nib, input logic up);
      logic [3:0] r;
      if (up) r = (nib == BCD_MAX) ? BCD_MIN : nib + 4'd1;
      else    r = (nib == BCD_MIN) ? BCD_MAX : nib - 4'd1;
      return r;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One packed-BCD digit of the counter chain.
//   iClk, iRst       : clock, async active-high reset
//   iStep            : step this digit this cycle
//   iUp              : 1 = increment, 0 = decrement
//   iLd, iLdVal[3:0] : parallel load (already validated by the parent)
//   iClr             : synchronous clear
//   oDigit[3:0]      : registered digit value
//   oChain           : carry/borrow out, iStep & at-limit-for-iUp
module bcd_digit
   import bcd_defs::*;
(
   input  logic       iClk,
   input  logic       iRst,
   input  logic       iStep,
   input  logic       iUp,
   input  logic       iLd,
   input  logic [3:0] iLdVal,
   input  logic       iClr,
   output logic [3:0] oDigit,
   output logic       oChain
);

   logic [3:0] digit_q, digit_d;

   always_comb begin
      digit_d = digit_q;
      if (iClr)       digit_d = BCD_MIN;
      else if (iLd)   digit_d = iLdVal;
      else if (iStep) digit_d = bcd_step(digit_q, iUp);
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) digit_q <= BCD_MIN;
      else      digit_q <= digit_d;
   end

   assign oChain = iStep & (iUp ? (digit_q == BCD_MAX) : (digit_q == BCD_MIN));
   assign oDigit = digit_q;

endmodule

// File: rtl/bcd_counter_n.sv
// N-digit packed-BCD up/down counter with clear, validated load and
// wrap-or-saturate behaviour at the range limits.
//   DIGITS   : number of BCD digits (1..8)
//   WRAP     : 1 = roll over at limits, 0 = saturate and hold
//   iClk, iRst           : clock, async active-high reset
//   iEn, iUp             : step request and direction
//   iClr, iLoad          : sync clear / parallel load (priority clr > load > en)
//   iLoadVal[4*DIGITS-1:0] : packed BCD load value, units in [3:0]
//   oCount   : registered packed BCD count
//   oTc      : combinational, count at limit for current iUp
//   oOvf     : one-cycle pulse, limit step wrapped or was blocked
//   oLoadErr : one-cycle pulse, load rejected for a non-BCD nibble
module bcd_counter_n
   import bcd_defs::*;
#(
   parameter int unsigned DIGITS = 3,
   parameter int unsigned WRAP   = 1
) (
   input  logic                      iClk,
   input  logic                      iRst,
   input  logic                      iEn,
   input  logic                      iUp,
   input  logic                      iClr,
   input  logic                      iLoad,
   input  logic [BCD_W*DIGITS-1:0]   iLoadVal,
   output logic [BCD_W*DIGITS-1:0]   oCount,
   output logic                      oTc,
   output logic                      oOvf,
   output logic                      oLoadErr
);

   localparam bit WRAP_EN = (WRAP != 0);

   logic [DIGITS:0] chain;
   logic            load_ok;
   logic            en_ok;
   logic            all_max, all_min;
   logic            ovf_q, ovf_d;
   logic            lerr_q, lerr_d;

   always_comb begin
      load_ok = 1'b1;
      all_max = 1'b1;
      all_min = 1'b1;
      for (int i = 0; i < int'(DIGITS); i++) begin
         load_ok = load_ok & is_bcd(iLoadVal[BCD_W*i +: BCD_W]);
         all_max = all_max & (oCount[BCD_W*i +: BCD_W] == BCD_MAX);
         all_min = all_min & (oCount[BCD_W*i +: BCD_W] == BCD_MIN);
      end
   end

   assign oTc   = iUp ? all_max : all_min;
   assign en_ok = iEn & ~iClr & ~iLoad;

   // In saturate mode the units digit is never stepped at the limit, which
   // freezes the whole chain and holds the count.
   assign chain[0] = en_ok & (WRAP_EN | ~oTc);

   for (genvar g = 0; g < int'(DIGITS); g++) begin : g_digit
      bcd_digit u_digit (
         .iClk   (iClk),
         .iRst   (iRst),
         .iStep  (chain[g]),
         .iUp    (iUp),
         .iLd    (iLoad & ~iClr & load_ok),
         .iLdVal (iLoadVal[BCD_W*g +: BCD_W]),
         .iClr   (iClr),
         .oDigit (oCount[BCD_W*g +: BCD_W]),
         .oChain (chain[g+1])
      );
   end

   // With wrapping, carry out of the top digit is exactly a limit crossing.
   assign ovf_d  = WRAP_EN ? chain[DIGITS] : (en_ok & oTc);
   assign lerr_d = ~iClr & iLoad & ~load_ok;

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         ovf_q  <= 1'b0;
         lerr_q <= 1'b0;
      end else begin
         ovf_q  <= ovf_d;
         lerr_q <= lerr_d;
      end
   end

   assign oOvf     = ovf_q;
   assign oLoadErr = lerr_q;

endmodule
